// File: rtl/demux1_4_reg_pkg.sv
// Shared lane definitions for the registered 1:4 demux.
// Lane count, select width and lane encodings.
package demux1_4_reg_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic [SEL_W-1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_e;

endpackage

// File: rtl/lane_reg.sv
// One-entry valid/data holding register for a demux lane.
// A load wins over a drain on the same edge, so there is no bubble.
module lane_reg
  import demux1_4_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             free
);

  assign free = ~valid | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1_4_reg.sv
// Registered 1:4 demux with valid/ready handshake.
// Lane picked by in_sel or by a round-robin pointer.
module demux1_4_reg
  import demux1_4_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               rr_en,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [1:0]         rr_ptr,
  output logic [CNT_W-1:0]   accept_cnt
);

  lane_e                tgt;
  logic                 accept;
  logic [NUM_LANES-1:0] free;
  logic [NUM_LANES-1:0] load;

  assign tgt      = lane_e'(rr_en ? rr_ptr : in_sel);
  assign in_ready = free[tgt];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    unique case (tgt)
      LANE0: load[0] = accept;
      LANE1: load[1] = accept;
      LANE2: load[2] = accept;
      LANE3: load[3] = accept;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[i]),
      .data (in_data),
      .ready(out_ready[i]),
      .valid(out_valid[i]),
      .q    (out_data[i*WIDTH +: WIDTH]),
      .free (free[i])
    );
  end

  // Pointer only moves on a round-robin accept; it never skips a full lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      accept_cnt <= '0;
    end else if (accept) begin
      accept_cnt <= accept_cnt + CNT_W'(1);
      if (rr_en) rr_ptr <= rr_ptr + 2'd1;
    end
  end

endmodule
